// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisors, time_set decode and receiver state encoding.
// Used by both the word receiver and the word transmitter.
package uart_pkg;

    localparam int DIV_W      = 13;
    localparam int DIV_9600   = 5208;
    localparam int DIV_19200  = 2604;
    localparam int DIV_38400  = 1302;
    localparam int DIV_57600  = 868;
    localparam int DIV_115200 = 434;
    localparam int NBYTES_DEF = 5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Unused select codes fall back to the slowest rate.
    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        logic [DIV_W-1:0] d;
        unique case (sel)
            3'd1:    d = DIV_W'(DIV_19200);
            3'd2:    d = DIV_W'(DIV_38400);
            3'd3:    d = DIV_W'(DIV_57600);
            3'd4:    d = DIV_W'(DIV_115200);
            default: d = DIV_W'(DIV_9600);
        endcase
        return d;
    endfunction

endpackage

// File: rtl/recv_byte.sv
// 8N1 byte receiver: input synchronizer, start/data/stop FSM and bit timing.
// Emits the byte with a one-cycle done pulse, or an error pulse on a low stop bit.
module recv_byte
    import uart_pkg::*;
(
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    input  logic [2:0] time_set,
    output logic [7:0] rx_byte,
    output logic       rx_done,
    output logic       rx_err,
    output logic       rx_idle
);

    logic             rx_s1;
    logic             rx_s2;
    logic             rx_d;
    logic             fall;
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_nxt;
    logic [7:0]       shreg;
    logic [7:0]       sh_nxt;
    logic [7:0]       byte_nxt;
    logic             done_nxt;
    logic             err_nxt;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign fall    = rx_d & ~rx_s2;
    assign rx_idle = (state == RX_IDLE);

    always_comb begin
        state_nxt = state;
        div_nxt   = div_q;
        cnt_nxt   = cnt + 1'b1;
        bit_nxt   = bit_idx;
        sh_nxt    = shreg;
        byte_nxt  = rx_byte;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            RX_IDLE: begin
                cnt_nxt = '0;
                if (fall) begin
                    // Rate is frozen here for the whole byte.
                    state_nxt = RX_START;
                    div_nxt   = baud_div(time_set);
                    cnt_nxt   = DIV_W'(1);
                end
            end
            RX_START: begin
                if (cnt == (div_q >> 1)) begin
                    state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                    cnt_nxt   = DIV_W'(1);
                    bit_nxt   = 3'd0;
                end
            end
            RX_DATA: begin
                if (cnt == div_q) begin
                    sh_nxt  = {rx_s2, shreg[7:1]};
                    cnt_nxt = DIV_W'(1);
                    bit_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == div_q) begin
                    state_nxt = RX_IDLE;
                    cnt_nxt   = '0;
                    byte_nxt  = shreg;
                    done_nxt  = rx_s2;
                    err_nxt   = ~rx_s2;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RX_IDLE;
            div_q   <= DIV_W'(DIV_9600);
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            rx_byte <= 8'h00;
            rx_done <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_q   <= div_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= sh_nxt;
            rx_byte <= byte_nxt;
            rx_done <= done_nxt;
            rx_err  <= err_nxt;
        end
    end

endmodule

// File: rtl/uart_word_rx.sv
// Reassembles NBYTES UART bytes (lowest byte first) into one parallel word,
// with frame-error and inter-byte timeout recovery.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int NBYTES       = NBYTES_DEF,
    parameter int TIMEOUT_CLKS = 104160
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  uart_rx,
    input  logic [2:0]            time_set,
    output logic [8*NBYTES-1:0]   data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  timeout_err,
    output logic                  busy
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    logic [7:0]    rx_byte;
    logic          rx_done;
    logic          rx_err;
    logic          rx_idle;
    logic [CW-1:0] byte_cnt;
    logic [W-1:0]  shadow;
    logic [W-1:0]  word_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_run;
    logic          tmo_hit;
    logic          last_byte;

    recv_byte u_recv_byte (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .time_set (time_set),
        .rx_byte  (rx_byte),
        .rx_done  (rx_done),
        .rx_err   (rx_err),
        .rx_idle  (rx_idle)
    );

    always_comb begin
        word_nxt = shadow;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_cnt == CW'(i)) word_nxt[i*8 +: 8] = rx_byte;
        end
    end

    assign last_byte = (byte_cnt == CW'(NBYTES - 1));
    assign tmo_run   = (byte_cnt != '0) && rx_idle;
    assign tmo_hit   = tmo_run && (tmo_cnt == TW'(TIMEOUT_CLKS - 1));
    assign busy      = (byte_cnt != '0) || !rx_idle;

    // Frame error outranks both a good byte and a timeout on the same cycle.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt    <= '0;
            shadow      <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            if (rx_err) begin
                frame_err <= 1'b1;
                byte_cnt  <= '0;
                tmo_cnt   <= '0;
            end else if (rx_done) begin
                shadow  <= word_nxt;
                tmo_cnt <= '0;
                if (last_byte) begin
                    byte_cnt   <= '0;
                    data_out   <= word_nxt;
                    data_valid <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + CW'(1);
                end
            end else if (tmo_hit) begin
                timeout_err <= 1'b1;
                byte_cnt    <= '0;
                tmo_cnt     <= '0;
            end else if (tmo_run) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Receives a multi-byte word over a UART line and reassembles it into a 40-bit parallel word. It is the receive-side counterpart of the existing 40-bit word transmitter. It expects 8N1 bytes, LSB-first, sent lowest byte of the word first, and raises a one-cycle valid pulse once all five bytes have arrived cleanly. It sits between the external RX pin and the consumer logic in the top module.

## Interface
Parameters:
- NBYTES, 5: bytes per word; the word width is 8*NBYTES.
- TIMEOUT_CLKS, 104160: maximum idle clocks allowed between bytes of one word (20 bit times at 9600 baud with a 50 MHz clock).

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous and active-low.
- uart_rx  in  1  asynchronous serial input; the line idles high.
- time_set  in  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200; values 5–7 select 9600.
- data_out  out  40  last complete word; holds until the next word completes.
- data_valid  out  1  one-cycle pulse when data_out updates.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- timeout_err  out  1  one-cycle pulse when a partial word is abandoned.
- busy  out  1  high while a word is partially received or a byte is in flight.

## Operation
- uart_rx passes through a 2-FF synchronizer. A start is detected on a falling edge of the synchronized line.
- time_set is latched at start detection and held for the whole byte.
- Divisors are 5208, 2604, 1302, 868 and 434 clocks per bit.
- Byte FSM states: IDLE → START → DATA → STOP → IDLE.
  - START: sample at half a divisor. If the line is high, it is a false start: return to IDLE with no output.
  - DATA: 8 samples, each one full divisor after the previous, shifted in LSB first.
  - STOP: sample one divisor after the last data bit, then return to IDLE immediately. A following start edge is accepted from the next cycle.
- Word assembly uses byte_cnt, which runs from 0 to NBYTES-1.
  - A good byte is written to data lane byte_cnt, so the first byte lands in [7:0].
  - byte_cnt increments after each good byte and wraps to 0 after byte NBYTES-1.
  - On that wrap, the shadow register is copied to data_out and data_valid is pulsed.
- Stop bit sampled low: frame_err pulses, the byte is dropped, byte_cnt goes to 0, and the partial word is discarded.
- Timeout counter:
  - Runs while byte_cnt ≠ 0 and the byte FSM is in IDLE.
  - Clears on every start detection.
  - On reaching TIMEOUT_CLKS: timeout_err pulses and byte_cnt goes to 0.
- If a frame error and a timeout fall on the same cycle, only frame_err pulses.
- busy = (byte_cnt ≠ 0) OR (byte FSM ≠ IDLE).
- Reset mid-operation discards all partial state. Reset values: data_out = 0, data_valid = 0, frame_err = 0, timeout_err = 0, busy = 0, byte_cnt = 0, FSM in IDLE.

## Timing
- Sampling points are measured from the synchronized falling edge: start bit at D/2, bit i at D/2 + (i+1)·D, stop bit at D/2 + 9·D.
- The byte receiver registers a one-cycle byte done signal one clock after the stop-sample edge.
- data_valid, frame_err and timeout_err are registered. data_valid and frame_err go high two clocks after the stop-sample edge.
- data_out changes only on the same edge that raises data_valid.
- Sustained back-to-back words with zero idle time between stop and next start must be received without loss at every baud rate.
- Input-to-sample latency includes 2 synchronizer clocks. This is tolerated within the ±2% baud mismatch budget.

## Structure
- Package uart_pkg holds:
  - the baud divisor constants and the time_set-to-divisor mapping function (shared with the transmitter side);
  - the byte FSM state encoding;
  - the default NBYTES.
- Sub-module recv_byte holds the synchronizer, byte FSM, bit counter and divisor counter. Its outputs are the byte, a done pulse and an error pulse.
- uart_word_rx holds byte_cnt, the shadow register, the timeout counter and the output registers.

## Test plan
- time_set=2, bytes 0x11, 0x22, 0x33, 0x44, 0x55 → data_out = 0x5544332211; exactly one data_valid pulse; busy low afterward.
- Low glitch of D/4 on an idle line → no byte accepted, byte_cnt stays 0, no pulses.
- Five-byte word where byte 3 has its stop bit at 0 → frame_err pulses, no data_valid. A following clean word 0xA5A5A5A5A5 is received correctly.
- Two bytes sent, then line idle for TIMEOUT_CLKS+10 clocks → timeout_err pulses once, busy falls. The next five bytes form the complete word.
- Assert rst_n low during the DATA state of byte 2 → all outputs return to reset values. A subsequent full word is received correctly.
- time_set=4, two back-to-back words with no idle gap, with time_set changed to 0 mid-byte → both words correct; the time_set change only takes effect from the next start bit.
